// File: rtl/canvas_writer_if.sv
// Command handshake bundle for canvas_writer: valid/ready plus opcode and operands.
interface canvas_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dir;
    logic [5:0] cmd_color;

    modport master (output cmd_valid, cmd_op, cmd_dir, cmd_color, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_dir, cmd_color, output cmd_ready);
endinterface

// File: rtl/canvas_writer.sv
// 40x30 cell canvas with cursor/pen command port, raster clear sweep and a
// registered read-first display read port.
module canvas_writer #(
    parameter logic [5:0] CLEAR_COLOR = 6'b101101,
    parameter logic [5:0] PEN_RESET   = 6'b111111
) (
    input  logic           clk,
    input  logic           rst,
    canvas_writer_if.slave cmd,
    input  logic [5:0]     rd_x,
    input  logic [4:0]     rd_y,
    output logic [5:0]     rd_pixel,
    output logic [5:0]     cursor_x,
    output logic [4:0]     cursor_y,
    output logic [5:0]     pen_color,
    output logic           busy
);
    localparam int unsigned Cells = 1200;
    localparam logic [5:0]  XMax  = 6'd39;
    localparam logic [4:0]  YMax  = 5'd29;

    typedef enum logic [1:0] {OpMove, OpPlot, OpClear, OpSetColor} op_e;
    typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;
    typedef enum logic {StIdle, StClear} state_e;

    state_e      state;
    logic [5:0]  sweep_x;
    logic [4:0]  sweep_y;
    logic [5:0]  mem [Cells];
    logic        we;
    logic [10:0] waddr;
    logic [10:0] raddr;
    logic [5:0]  wdata;
    logic        rd_in_range;

    function automatic logic [10:0] cell_addr(input logic [5:0] x, input logic [4:0] y);
        return 11'(y) * 11'd40 + 11'(x);
    endfunction

    // The sweep owns the write port while clearing; otherwise only an accepted PLOT writes.
    always_comb begin
        we    = 1'b0;
        waddr = cell_addr(cursor_x, cursor_y);
        wdata = pen_color;
        if (state == StClear) begin
            we    = !rst;
            waddr = cell_addr(sweep_x, sweep_y);
            wdata = CLEAR_COLOR;
        end else if (cmd.cmd_valid && op_e'(cmd.cmd_op) == OpPlot) begin
            we = !rst;
        end
    end

    assign rd_in_range = (rd_x <= XMax) && (rd_y <= YMax);
    assign raddr       = cell_addr(rd_x, rd_y);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pixel <= '0;
        end else begin
            rd_pixel <= rd_in_range ? mem[raddr] : '0;
        end
    end

    // Reset lands in StClear so the array is swept before the first command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StClear;
            sweep_x       <= '0;
            sweep_y       <= '0;
            cursor_x      <= '0;
            cursor_y      <= '0;
            pen_color     <= PEN_RESET;
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd.cmd_valid) begin
                        unique case (op_e'(cmd.cmd_op))
                            OpMove: begin
                                unique case (dir_e'(cmd.cmd_dir))
                                    DirUp:    if (cursor_y != 5'd0) cursor_y <= cursor_y - 5'd1;
                                    DirDown:  if (cursor_y != YMax) cursor_y <= cursor_y + 5'd1;
                                    DirLeft:  if (cursor_x != 6'd0) cursor_x <= cursor_x - 6'd1;
                                    DirRight: if (cursor_x != XMax) cursor_x <= cursor_x + 6'd1;
                                endcase
                            end
                            OpPlot: begin
                            end
                            OpClear: begin
                                state         <= StClear;
                                sweep_x       <= '0;
                                sweep_y       <= '0;
                                cmd.cmd_ready <= 1'b0;
                                busy          <= 1'b1;
                            end
                            OpSetColor: pen_color <= cmd.cmd_color;
                        endcase
                    end
                end
                StClear: begin
                    if (sweep_x == XMax && sweep_y == YMax) begin
                        state         <= StIdle;
                        sweep_x       <= '0;
                        sweep_y       <= '0;
                        cmd.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                    end else if (sweep_x == XMax) begin
                        sweep_x <= '0;
                        sweep_y <= sweep_y + 5'd1;
                    end else begin
                        sweep_x <= sweep_x + 6'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_canvas_writer.sv
// Randomised bench for canvas_writer: a cell-list model plus literal directed checks.
module tb_canvas_writer;
    localparam logic [5:0] ClearColor = 6'b101101;
    localparam logic [5:0] PenReset   = 6'b111111;
    localparam int         NCells     = 1200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] rd_x = '0;
    logic [4:0] rd_y = '0;
    logic [5:0] rd_pixel;
    logic [5:0] cursor_x;
    logic [4:0] cursor_y;
    logic [5:0] pen_color;
    logic       busy;

    canvas_writer_if cmd_bus ();

    canvas_writer dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_bus.slave),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_pixel (rd_pixel),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .pen_color(pen_color),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: cursor, pen, remaining clear cells, and the cell list itself.
    int         m_x;
    int         m_y;
    logic [5:0] m_pen;
    int         m_left;
    int         m_idx;
    logic [5:0] m_mem [NCells];
    bit         m_known [NCells];
    logic [5:0] m_rd;
    bit         m_rd_known;
    bit         chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x        = 0;
        m_y        = 0;
        m_pen      = PenReset;
        m_left     = NCells;
        m_idx      = 0;
        m_rd       = '0;
        m_rd_known = 1'b1;
    endtask

    task automatic model_step();
        int a;
        if (rst) return;
        if (rd_x < 40 && rd_y < 30) begin
            a          = int'(rd_y) * 40 + int'(rd_x);
            m_rd       = m_mem[a];
            m_rd_known = m_known[a];
        end else begin
            m_rd       = '0;
            m_rd_known = 1'b1;
        end
        if (m_left > 0) begin
            m_mem[m_idx]   = ClearColor;
            m_known[m_idx] = 1'b1;
            m_idx++;
            m_left--;
        end else if (cmd_bus.cmd_valid) begin
            case (cmd_bus.cmd_op)
                2'b00: case (cmd_bus.cmd_dir)
                    2'b00: if (m_y > 0)  m_y--;
                    2'b01: if (m_y < 29) m_y++;
                    2'b10: if (m_x > 0)  m_x--;
                    default: if (m_x < 39) m_x++;
                endcase
                2'b01: begin
                    m_mem[m_y * 40 + m_x]   = m_pen;
                    m_known[m_y * 40 + m_x] = 1'b1;
                end
                2'b10: begin
                    m_left = NCells;
                    m_idx  = 0;
                end
                default: m_pen = cmd_bus.cmd_color;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(m_left == 0));
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("cursor_x", 32'(cursor_x), 32'(m_x));
            chk("cursor_y", 32'(cursor_y), 32'(m_y));
            chk("pen_color", 32'(pen_color), 32'(m_pen));
            if (m_rd_known) chk("rd_pixel", 32'(rd_pixel), 32'(m_rd));
        end
    end

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] dir, input logic [5:0] col);
        bit acc = 1'b0;
        int n   = 0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_dir   = dir;
        cmd_bus.cmd_color = col;
        while (!acc && n < 3000) begin
            acc = cmd_bus.cmd_ready;
            tick();
            n++;
        end
        cmd_bus.cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_at(input int x, input int y, output logic [5:0] v);
        rd_x = 6'(x);
        rd_y = 5'(y);
        tick();
        v = rd_pixel;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_bus.cmd_ready && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd1200);
    endtask

    logic [5:0] v;
    int         n;

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = '0;
        cmd_bus.cmd_dir   = '0;
        cmd_bus.cmd_color = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        chk("reset_pen", 32'(pen_color), 32'(PenReset));
        chk("reset_rd", 32'(rd_pixel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("init_sweep_len");

        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 40; x++) begin
                read_at(x, y, v);
                chk("init_cell", 32'(v), 32'(ClearColor));
            end
        end

        send(2'b11, 2'b00, 6'b110000);
        repeat (3) send(2'b00, 2'b11, '0);
        repeat (2) send(2'b00, 2'b01, '0);
        send(2'b01, 2'b00, '0);
        chk("plot_cx", 32'(cursor_x), 32'd3);
        chk("plot_cy", 32'(cursor_y), 32'd2);
        read_at(3, 2, v);
        chk("plot_cell", 32'(v), 32'h30);
        read_at(2, 2, v);
        chk("plot_neighbour", 32'(v), 32'(ClearColor));

        repeat (3) send(2'b00, 2'b10, '0);
        repeat (2) send(2'b00, 2'b00, '0);
        send(2'b00, 2'b00, '0);
        send(2'b00, 2'b10, '0);
        chk("sat_low_x", 32'(cursor_x), 32'd0);
        chk("sat_low_y", 32'(cursor_y), 32'd0);
        repeat (45) send(2'b00, 2'b11, '0);
        repeat (35) send(2'b00, 2'b01, '0);
        chk("sat_high_x", 32'(cursor_x), 32'd39);
        chk("sat_high_y", 32'(cursor_y), 32'd29);

        send(2'b11, 2'b00, 6'b010101);
        send(2'b01, 2'b00, '0);
        send(2'b10, 2'b00, '0);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 2'b01;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("clear_busy_len", 32'(n), 32'd1200);
        tick();
        cmd_bus.cmd_valid = 1'b0;
        read_at(39, 29, v);
        chk("held_plot", 32'(v), 32'h15);
        read_at(38, 29, v);
        chk("cleared_cell", 32'(v), 32'(ClearColor));

        read_at(40, 0, v);
        chk("oob_x", 32'(v), 32'd0);
        read_at(0, 30, v);
        chk("oob_y", 32'(v), 32'd0);
        repeat (34) send(2'b00, 2'b10, '0);
        repeat (24) send(2'b00, 2'b00, '0);
        send(2'b11, 2'b00, 6'b000111);
        rd_x = 6'd5;
        rd_y = 5'd5;
        send(2'b01, 2'b00, '0);
        chk("rw_old", 32'(rd_pixel), 32'(ClearColor));
        tick();
        chk("rw_new", 32'(rd_pixel), 32'h07);

        send(2'b10, 2'b00, '0);
        repeat (600) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_cx", 32'(cursor_x), 32'd0);
        chk("arst_cy", 32'(cursor_y), 32'd0);
        chk("arst_pen", 32'(pen_color), 32'(PenReset));
        chk("arst_rd", 32'(rd_pixel), 32'd0);
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0;
        wait_ready("restart_sweep_len");

        for (int i = 0; i < 4000; i++) begin
            cmd_bus.cmd_valid = 1'($urandom_range(0, 1));
            cmd_bus.cmd_op    = 2'($urandom_range(0, 3));
            if (cmd_bus.cmd_op == 2'b10 && $urandom_range(0, 63) != 0) cmd_bus.cmd_op = 2'b01;
            cmd_bus.cmd_dir   = 2'($urandom_range(0, 3));
            cmd_bus.cmd_color = 6'($urandom_range(0, 63));
            rd_x              = 6'($urandom_range(0, 45));
            rd_y              = 5'($urandom_range(0, 33));
            tick();
        end
        cmd_bus.cmd_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
